tis_core: RTL and testbench



---
 rtl/tis_core.sv | 129 ++++++++++++
 tb/tb_tis_core.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tis_core.sv
// Single TIS-100-style execution node: one instruction per clock from a 15-word program,
// with a saturating 11-bit accumulator, a backup register and a wrapping program counter.
module tis_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pLength,
    input  logic [15:0] prog [0:14],
    output logic [10:0] acc
);

    typedef enum logic [3:0] {
        OpNop = 4'h0,
        OpMov = 4'h1,
        OpSwp = 4'h2,
        OpSav = 4'h3,
        OpAdd = 4'h4,
        OpSub = 4'h5,
        OpNeg = 4'h6,
        OpJmp = 4'h7,
        OpJez = 4'h8,
        OpJnz = 4'h9,
        OpJgz = 4'hA,
        OpJlz = 4'hB,
        OpJro = 4'hC
    } op_e;

    localparam logic signed [11:0] SatMax = 12'sd999;
    localparam logic signed [11:0] SatMin = -12'sd999;

    logic [10:0] acc_q, acc_d;
    logic [10:0] bak_q, bak_d;
    logic [3:0]  pc_q, pc_d;

    logic [15:0]        instr;
    logic               pc_valid;
    op_e                op;
    logic signed [11:0] acc_s;
    logic signed [11:0] src;
    logic [4:0]         pc_inc;
    logic [3:0]         pc_seq;
    logic [3:0]         pc_tgt;
    logic [3:0]         pc_max;
    logic signed [12:0] jro_sum;
    logic [3:0]         pc_jro;

    function automatic logic [10:0] sat(input logic signed [11:0] v);
        if (v > SatMax) begin
            return SatMax[10:0];
        end else if (v < SatMin) begin
            return SatMin[10:0];
        end
        return v[10:0];
    endfunction

    // Mux instead of direct indexing keeps a stale PC of 15 from reading past the array.
    always_comb begin
        instr = 16'h0000;
        for (int i = 0; i < 15; i++) begin
            if (pc_q == 4'(i)) begin
                instr = prog[i];
            end
        end
    end

    assign pc_valid = pc_q < pLength;
    assign op       = op_e'(instr[15:12]);
    assign acc_s    = $signed({acc_q[10], acc_q});
    assign src      = instr[11] ? acc_s : $signed({instr[10], instr[10:0]});

    assign pc_inc  = {1'b0, pc_q} + 5'd1;
    assign pc_seq  = (pc_inc == {1'b0, pLength}) ? 4'd0 : pc_inc[3:0];
    assign pc_tgt  = (instr[3:0] >= pLength) ? 4'd0 : instr[3:0];
    assign pc_max  = pLength - 4'd1;
    assign jro_sum = $signed({9'b0, pc_q}) + $signed({src[11], src});

    always_comb begin
        if (jro_sum < 13'sd0) begin
            pc_jro = 4'd0;
        end else if (jro_sum > $signed({9'b0, pc_max})) begin
            pc_jro = pc_max;
        end else begin
            pc_jro = jro_sum[3:0];
        end
    end

    always_comb begin
        acc_d = acc_q;
        bak_d = bak_q;
        pc_d  = pc_seq;
        if (!pc_valid) begin
            // Covers pLength == 0 and a PC stranded by a runtime pLength reduction.
            pc_d = 4'd0;
        end else begin
            case (op)
                OpMov: acc_d = sat(src);
                OpSwp: begin
                    acc_d = bak_q;
                    bak_d = acc_q;
                end
                OpSav: bak_d = acc_q;
                OpAdd: acc_d = sat(acc_s + src);
                OpSub: acc_d = sat(acc_s - src);
                OpNeg: acc_d = sat(-acc_s);
                OpJmp: pc_d = pc_tgt;
                OpJez: if (acc_s == 12'sd0) pc_d = pc_tgt;
                OpJnz: if (acc_s != 12'sd0) pc_d = pc_tgt;
                OpJgz: if (acc_s > 12'sd0) pc_d = pc_tgt;
                OpJlz: if (acc_s < 12'sd0) pc_d = pc_tgt;
                OpJro: pc_d = pc_jro;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
            bak_q <= '0;
            pc_q  <= '0;
        end else begin
            acc_q <= acc_d;
            bak_q <= bak_d;
            pc_q  <= pc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: tb/tb_tis_core.sv
// Scoreboard bench for tis_core: expected ACC values are queued with the stimulus
// and compared one per clock, sampled 1 ns after the rising edge.
module tb_tis_core;

    logic        clk;
    logic        rst;
    logic [3:0]  pLength;
    logic [15:0] prog [0:14];
    logic [10:0] acc;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];

    tis_core dut (
        .clk     (clk),
        .rst     (rst),
        .pLength (pLength),
        .prog    (prog),
        .acc     (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_prog();
        for (int i = 0; i < 15; i++) prog[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        clear_prog();
        prog[0] = 16'h4005;
        pLength = 4'd1;
        do_reset();
        checks++;
        if (acc !== 11'd0) begin
            failures++;
            $display("FAIL reset_initial acc=%0d expected=0", $signed(acc));
        end
        for (int i = 1; i <= 3; i++) exp_q.push_back(11'(5 * i));
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (acc !== e) begin
                failures++;
                $display("FAIL reset_run acc=%0d expected=%0d", $signed(acc), $signed(e));
            end
        end
        do_reset();
        checks++;
        if (acc !== 11'd0) begin
            failures++;
            $display("FAIL reset_again acc=%0d expected=0", $signed(acc));
        end
        // First edge after release must execute prog[0], proving PC was cleared.
        @(posedge clk);
        #1;
        checks++;
        if (acc !== 11'd5) begin
            failures++;
            $display("FAIL reset_first_instr acc=%0d expected=5", $signed(acc));
        end
    endtask

    task automatic test_counter();
        logic [10:0] e;
        clear_prog();
        prog[0] = 16'h4001;
        prog[1] = 16'h0000;
        pLength = 4'd2;
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(11'((i / 2) + 1));
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (acc !== e) begin
                failures++;
                $display("FAIL counter acc=%0d expected=%0d", $signed(acc), $signed(e));
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0]        pv [11];
        logic signed [10:0] ev [11];
        logic [10:0]        e;
        pv = '{16'h41F4, 16'h41F4, 16'h41F4, 16'h6000, 16'h5001, 16'h6000,
               16'h1400, 16'h13FF, 16'h17F9, 16'h4800, 16'h5800};
        ev = '{11'sd500, 11'sd999, 11'sd999, -11'sd999, -11'sd999, 11'sd999,
               -11'sd999, 11'sd999, -11'sd7, -11'sd14, 11'sd0};
        clear_prog();
        prog[0] = pv[0];
        pLength = 4'd1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            prog[0] = pv[i];
            exp_q.push_back(ev[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (acc !== e) begin
                failures++;
                $display("FAIL saturation[%0d] acc=%0d expected=%0d", i, $signed(acc), $signed(e));
            end
        end
    endtask

    task automatic test_swp_sav();
        logic signed [10:0] ev [7];
        logic [10:0]        e;
        ev = '{11'sd7, 11'sd7, 11'sd3, 11'sd7, 11'sd3, 11'sd3, 11'sd3};
        clear_prog();
        prog[0] = 16'h1007;
        prog[1] = 16'h3000;
        prog[2] = 16'h1003;
        prog[3] = 16'h2000;
        prog[4] = 16'h2000;
        prog[5] = 16'hC000;
        pLength = 4'd6;
        do_reset();
        for (int i = 0; i < 7; i++) exp_q.push_back(ev[i]);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (acc !== e) begin
                failures++;
                $display("FAIL swp_sav acc=%0d expected=%0d", $signed(acc), $signed(e));
            end
        end
    endtask

    task automatic test_branches();
        logic [15:0] bp [6][4];
        int          be [6][6];
        logic [10:0] e;
        bp = '{'{16'h1000, 16'h8003, 16'h4064, 16'h4001},
               '{16'h4001, 16'h9000, 16'h4064, 16'h4001},
               '{16'h1005, 16'hA003, 16'h4064, 16'h4001},
               '{16'h17FB, 16'hB003, 16'h4064, 16'h4001},
               '{16'h17FB, 16'hA003, 16'h4064, 16'h4001},
               '{16'h1002, 16'hC800, 16'h4064, 16'h4001}};
        be = '{'{0, 0, 1, 0, 0, 1},
               '{1, 1, 2, 2, 3, 3},
               '{5, 5, 6, 5, 5, 6},
               '{-5, -5, -4, -5, -5, -4},
               '{-5, -5, 95, 96, -5, -5},
               '{2, 2, 3, 2, 2, 3}};
        for (int c = 0; c < 6; c++) begin
            clear_prog();
            for (int k = 0; k < 4; k++) prog[k] = bp[c][k];
            pLength = 4'd4;
            do_reset();
            for (int i = 0; i < 6; i++) exp_q.push_back(11'(be[c][i]));
            while (exp_q.size() > 0) begin
                @(posedge clk);
                #1;
                e = exp_q.pop_front();
                checks++;
                if (acc !== e) begin
                    failures++;
                    $display("FAIL branch_case%0d acc=%0d expected=%0d", c, $signed(acc),
                             $signed(e));
                end
            end
        end
    endtask

    task automatic test_jro();
        logic [10:0] e;
        clear_prog();
        prog[0] = 16'h4001;
        prog[1] = 16'h4001;
        prog[2] = 16'hC7F8;
        prog[3] = 16'h4064;
        pLength = 4'd4;
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(11'((i / 3) * 2 + ((i % 3) > 0 ? 2 : 1)));
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (acc !== e) begin
                failures++;
                $display("FAIL jro_neg acc=%0d expected=%0d", $signed(acc), $signed(e));
            end
        end
        clear_prog();
        prog[0] = 16'h4003;
        prog[1] = 16'hC000;
        pLength = 4'd2;
        do_reset();
        for (int i = 0; i < 11; i++) exp_q.push_back(11'd3);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (acc !== e) begin
                failures++;
                $display("FAIL jro_halt acc=%0d expected=%0d", $signed(acc), $signed(e));
            end
        end
    endtask

    task automatic test_jmp_range();
        logic [10:0] e;
        clear_prog();
        prog[0] = 16'h4001;
        prog[1] = 16'h700E;
        prog[2] = 16'h4064;
        prog[3] = 16'h4064;
        pLength = 4'd4;
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(11'((i / 2) + 1));
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (acc !== e) begin
                failures++;
                $display("FAIL jmp_range acc=%0d expected=%0d", $signed(acc), $signed(e));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] e;
        clear_prog();
        prog[0] = 16'h4001;
        pLength = 4'd2;
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(11'((i / 2) + 1));
        exp_q.push_back(11'd0);
        exp_q.push_back(11'd1);
        for (int i = 0; i < 7; i++) begin
            rst = (i == 5) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (acc !== e) begin
                failures++;
                $display("FAIL reset_mid[%0d] acc=%0d expected=%0d", i, $signed(acc), $signed(e));
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_plength();
        logic [3:0]  lv [11];
        int          ev [11];
        logic [10:0] e;
        lv = '{4'd4, 4'd4, 4'd4, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1};
        ev = '{1, 2, 3, 3, 4, 5, 5, 5, 5, 6, 7};
        clear_prog();
        for (int k = 0; k < 4; k++) prog[k] = 16'h4001;
        for (int k = 4; k < 15; k++) prog[k] = 16'h4064;
        pLength = 4'd4;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            pLength = lv[i];
            exp_q.push_back(11'(ev[i]));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (acc !== e) begin
                failures++;
                $display("FAIL plength[%0d] acc=%0d expected=%0d", i, $signed(acc), $signed(e));
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        pLength = 4'd0;
        clear_prog();
        test_reset();
        test_counter();
        test_saturation();
        test_swp_sav();
        test_branches();
        test_jro();
        test_jmp_range();
        test_reset_mid();
        test_plength();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
